matrix_rom_loader: RTL and testbench

//  Loads one test case (weight matrix, data matrix, expected result) from a

---
 rtl/matrix_rom_loader_pkg.sv | 40 ++++
 rtl/matrix_rom_loader_addr_gen.sv | 55 +++++
 rtl/matrix_rom_loader.sv | 200 ++++++++++++++++++++
 tb/tb_matrix_rom_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_rom_loader_pkg.sv
// ---------------------------------------------------------------------------
// matrix_loader_pkg
//   Shared definitions for the matrix ROM loader: the load FSM state encoding,
//   helper functions that derive the ROM case layout from the array geometry,
//   and element typedefs for the default 8-bit data path.
//   A case is stored as: weights (row-major), data (row-major), then the
//   expected result (row-major, two words per element, low half first).
// ---------------------------------------------------------------------------
package matrix_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_LOAD_R = 3'd3,
        ST_FIN    = 3'd4
    } loader_state_e;

    localparam int ELEM_WIDTH = 8;
    typedef logic [ELEM_WIDTH-1:0]   elem_t;
    typedef logic [2*ELEM_WIDTH-1:0] result_elem_t;

    function automatic int weight_words(input int w_w, input int w_l);
        return w_w * w_l;
    endfunction

    function automatic int data_words(input int a_w, input int a_l);
        return a_w * a_l;
    endfunction

    function automatic int result_words(input int w_w, input int a_l);
        return 2 * w_w * a_l;
    endfunction

    function automatic int case_words(input int w_w, input int w_l,
                                      input int a_w, input int a_l);
        return weight_words(w_w, w_l) + data_words(a_w, a_l) + result_words(w_w, a_l);
    endfunction

endpackage

// File: rtl/matrix_rom_loader_addr_gen.sv
// ---------------------------------------------------------------------------
// loader_addr_gen
//   Holds the base address of the selected case and an offset counter that
//   walks through the case one word per advance. Flags the last word of the
//   weight, data and result segments so the FSM can change state without gaps.
// Ports
//   clk, reset_n   clock, async active-low reset
//   i_load         latch i_base and clear the offset
//   i_base         case base address
//   i_advance      step the offset (held once the last word is reached)
//   o_addr         base + offset, drives the ROM address
//   o_offset       word offset within the case
//   o_end_w/b/r    offset is the last word of the weight/data/result segment
// ---------------------------------------------------------------------------
module loader_addr_gen #(
    parameter int ADDR_WIDTH = 7,
    parameter int WORDS_W    = 10,
    parameter int WORDS_B    = 10,
    parameter int CASE_WORDS = 28
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ADDR_WIDTH-1:0] o_offset,
    output logic                  o_end_w,
    output logic                  o_end_b,
    output logic                  o_end_r
);

    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_offset;

    // Offset stops on the final word so the address never wraps past the case.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base   <= '0;
            r_offset <= '0;
        end else if (i_load) begin
            r_base   <= i_base;
            r_offset <= '0;
        end else if (i_advance && !o_end_r) begin
            r_offset <= r_offset + 1'b1;
        end
    end

    assign o_addr   = r_base + r_offset;
    assign o_offset = r_offset;
    assign o_end_w  = (r_offset == ADDR_WIDTH'(WORDS_W - 1));
    assign o_end_b  = (r_offset == ADDR_WIDTH'(WORDS_W + WORDS_B - 1));
    assign o_end_r  = (r_offset == ADDR_WIDTH'(CASE_WORDS - 1));

endmodule

// File: rtl/matrix_rom_loader.sv
// ---------------------------------------------------------------------------
// matrix_rom_loader
//   Loads one test case (weight matrix, data matrix, expected product) from a
//   synchronous ROM into packed matrix registers, one word per cycle.
// Ports
//   clk, reset_n   clock, async active-low reset
//   start          begin a load (only honoured while idle)
//   case_sel       case index sampled with start
//   busy           load in progress
//   done           one-cycle pulse at end of load
//   err            pulses with done when case_sel is out of range
//   data_valid     matrix outputs hold a complete case
//   rom_rd_en      ROM read strobe
//   rom_addr       ROM word address
//   rom_rdata      ROM data, valid the cycle after rom_rd_en
//   data_rom_w     weight matrix   [W_W][W_L]
//   data_rom_b     data matrix     [A_W][A_L]
//   result         expected result [W_W][A_L], 2*DATA_WIDTH per element
// ---------------------------------------------------------------------------
module matrix_rom_loader
    import matrix_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W_W  = 2,
    parameter int ARRAY_W_L  = 5,
    parameter int ARRAY_A_W  = 5,
    parameter int ARRAY_A_L  = 2,
    parameter int NUM_CASES  = 4,
    localparam int CASE_WORDS = case_words(ARRAY_W_W, ARRAY_W_L, ARRAY_A_W, ARRAY_A_L),
    localparam int ADDR_WIDTH = $clog2(NUM_CASES * CASE_WORDS),
    localparam int SEL_WIDTH  = (NUM_CASES > 1) ? $clog2(NUM_CASES) : 1
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic                                                start,
    input  logic [SEL_WIDTH-1:0]                                case_sel,
    output logic                                                busy,
    output logic                                                done,
    output logic                                                err,
    output logic                                                data_valid,
    output logic                                                rom_rd_en,
    output logic [ADDR_WIDTH-1:0]                               rom_addr,
    input  logic [DATA_WIDTH-1:0]                               rom_rdata,
    output logic [ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0]   data_rom_w,
    output logic [ARRAY_A_W-1:0][ARRAY_A_L-1:0][DATA_WIDTH-1:0]   data_rom_b,
    output logic [ARRAY_W_W-1:0][ARRAY_A_L-1:0][2*DATA_WIDTH-1:0] result
);

    localparam int WORDS_W = weight_words(ARRAY_W_W, ARRAY_W_L);
    localparam int WORDS_B = data_words(ARRAY_A_W, ARRAY_A_L);
    localparam int OFF_B   = WORDS_W;
    localparam int OFF_R   = WORDS_W + WORDS_B;
    localparam int NUM_R   = ARRAY_W_W * ARRAY_A_L;

    if (ARRAY_W_L != ARRAY_A_W) begin : g_dim_check
        $error("matrix_rom_loader: ARRAY_W_L must equal ARRAY_A_W");
    end

    loader_state_e         r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_data_valid;
    logic                  r_wr_valid;
    logic [ADDR_WIDTH-1:0] r_wr_idx;
    logic [DATA_WIDTH-1:0] r_prev_word;

    logic                  w_sel_valid;
    logic                  w_accept;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_end_w;
    logic                  w_end_b;
    logic                  w_end_r;

    // When NUM_CASES fills the select range every index is legal; comparing
    // would otherwise be a constant expression.
    if (NUM_CASES == (1 << SEL_WIDTH)) begin : g_sel_full
        assign w_sel_valid = 1'b1;
    end else begin : g_sel_range
        assign w_sel_valid = (case_sel < SEL_WIDTH'(NUM_CASES));
    end

    assign w_accept = (r_state == ST_IDLE) && start && w_sel_valid;
    assign w_base   = ADDR_WIDTH'(case_sel) * ADDR_WIDTH'(CASE_WORDS);
    assign w_rd_en  = (r_state == ST_LOAD_W) || (r_state == ST_LOAD_B) ||
                      (r_state == ST_LOAD_R);

    loader_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORDS_W    (WORDS_W),
        .WORDS_B    (WORDS_B),
        .CASE_WORDS (CASE_WORDS)
    ) u_addr_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_accept),
        .i_base    (w_base),
        .i_advance (w_rd_en),
        .o_addr    (w_addr),
        .o_offset  (w_offset),
        .o_end_w   (w_end_w),
        .o_end_b   (w_end_b),
        .o_end_r   (w_end_r)
    );

    // Load sequencer. FIN covers the cycle in which the last ROM word is
    // captured, so done/data_valid rise together with complete matrices.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_data_valid <= 1'b0;
                        if (w_sel_valid) begin
                            r_state <= ST_LOAD_W;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end
                    end
                end
                ST_LOAD_W: if (w_end_w) r_state <= ST_LOAD_B;
                ST_LOAD_B: if (w_end_b) r_state <= ST_LOAD_R;
                ST_LOAD_R: if (w_end_r) r_state <= ST_FIN;
                ST_FIN: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b1;
                    r_data_valid <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The write index trails the read address by one cycle to line up with
    // the ROM latency. The previous word is kept so a result element can be
    // written whole when its high half arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_valid  <= 1'b0;
            r_wr_idx    <= '0;
            r_prev_word <= '0;
        end else begin
            r_wr_valid <= w_rd_en;
            r_wr_idx   <= w_offset;
            if (r_wr_valid) r_prev_word <= rom_rdata;
        end
    end

    for (genvar e = 0; e < WORDS_W; e++) begin : g_w
        logic [DATA_WIDTH-1:0] r_elem;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) r_elem <= '0;
            else if (r_wr_valid && (r_wr_idx == ADDR_WIDTH'(e))) r_elem <= rom_rdata;
        end
        assign data_rom_w[e / ARRAY_W_L][e % ARRAY_W_L] = r_elem;
    end

    for (genvar e = 0; e < WORDS_B; e++) begin : g_b
        logic [DATA_WIDTH-1:0] r_elem;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) r_elem <= '0;
            else if (r_wr_valid && (r_wr_idx == ADDR_WIDTH'(OFF_B + e))) r_elem <= rom_rdata;
        end
        assign data_rom_b[e / ARRAY_A_L][e % ARRAY_A_L] = r_elem;
    end

    // Result elements update only on their high word, so a half-written
    // value never appears on the output.
    for (genvar e = 0; e < NUM_R; e++) begin : g_r
        logic [2*DATA_WIDTH-1:0] r_elem;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) r_elem <= '0;
            else if (r_wr_valid && (r_wr_idx == ADDR_WIDTH'(OFF_R + 2*e + 1)))
                r_elem <= {rom_rdata, r_prev_word};
        end
        assign result[e / ARRAY_A_L][e % ARRAY_A_L] = r_elem;
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign data_valid = r_data_valid;
    assign rom_rd_en  = w_rd_en;
    assign rom_addr   = w_addr;

endmodule

// File: tb/tb_matrix_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_matrix_rom_loader
//   Builds a ROM image from random (and one fixed) matrix cases whose result
//   is the true matrix product, loads cases through the loader and compares
//   the matrix outputs, address stream and handshake timing against that
//   model. A second instance with three cases covers the out-of-range select.
// ---------------------------------------------------------------------------
module tb_matrix_rom_loader;

    localparam int DW  = 8;
    localparam int WW  = 2;
    localparam int WL  = 5;
    localparam int AW  = 5;
    localparam int AL  = 2;
    localparam int NC  = 4;
    localparam int CW  = WW*WL + AW*AL + 2*WW*AL;
    localparam int ADW = 7;

    typedef logic [WW-1:0][WL-1:0][DW-1:0]   wmat_t;
    typedef logic [AW-1:0][AL-1:0][DW-1:0]   bmat_t;
    typedef logic [WW-1:0][AL-1:0][2*DW-1:0] rmat_t;

    logic           clk      = 1'b0;
    logic           reset_n  = 1'b0;
    logic           start    = 1'b0;
    logic [1:0]     case_sel = 2'd0;
    logic           busy, done, err, data_valid, rom_rd_en;
    logic [ADW-1:0] rom_addr;
    logic [DW-1:0]  rom_rdata = '0;
    wmat_t          data_rom_w;
    bmat_t          data_rom_b;
    rmat_t          result;

    logic           start2    = 1'b0;
    logic [1:0]     case_sel2 = 2'd0;
    logic           busy2, done2, err2, data_valid2, rom_rd_en2;
    logic [ADW-1:0] rom_addr2;
    logic [DW-1:0]  rom_rdata2 = '0;
    wmat_t          data_rom_w2;
    bmat_t          data_rom_b2;
    rmat_t          result2;

    logic [DW-1:0]   romMem [128];
    logic [DW-1:0]   wMod [NC][WW][WL];
    logic [DW-1:0]   bMod [NC][AW][AL];
    logic [2*DW-1:0] rMod [NC][WW][AL];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_rd_en)  rom_rdata  <= romMem[rom_addr];
    always @(posedge clk) if (rom_rd_en2) rom_rdata2 <= romMem[rom_addr2];

    matrix_rom_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .case_sel(case_sel),
        .busy(busy), .done(done), .err(err), .data_valid(data_valid),
        .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .data_rom_w(data_rom_w), .data_rom_b(data_rom_b), .result(result)
    );

    matrix_rom_loader #(.NUM_CASES(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .case_sel(case_sel2),
        .busy(busy2), .done(done2), .err(err2), .data_valid(data_valid2),
        .rom_rd_en(rom_rd_en2), .rom_addr(rom_addr2), .rom_rdata(rom_rdata2),
        .data_rom_w(data_rom_w2), .data_rom_b(data_rom_b2), .result(result2)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Case 0 is the fixed default image; the others are random. Results are
    // the true product truncated to 2*DW bits.
    task automatic buildModel();
        int sum;
        int base;
        for (int a = 0; a < 128; a++) romMem[a] = '0;
        for (int cs = 0; cs < NC; cs++) begin
            base = cs * CW;
            for (int i = 0; i < WW; i++)
                for (int k = 0; k < WL; k++)
                    wMod[cs][i][k] = (cs == 0) ? DW'(i*10 + k) : DW'($urandom_range(0, 255));
            for (int r = 0; r < AW; r++)
                for (int c = 0; c < AL; c++)
                    bMod[cs][r][c] = (cs == 0) ? DW'(r*2 + c) : DW'($urandom_range(0, 255));
            for (int i = 0; i < WW; i++)
                for (int j = 0; j < AL; j++) begin
                    sum = 0;
                    for (int k = 0; k < WL; k++) sum += int'(wMod[cs][i][k]) * int'(bMod[cs][k][j]);
                    rMod[cs][i][j] = 16'(sum);
                end
            for (int i = 0; i < WW; i++)
                for (int k = 0; k < WL; k++) romMem[base + i*WL + k] = wMod[cs][i][k];
            for (int r = 0; r < AW; r++)
                for (int c = 0; c < AL; c++) romMem[base + WW*WL + r*AL + c] = bMod[cs][r][c];
            for (int i = 0; i < WW; i++)
                for (int j = 0; j < AL; j++) begin
                    romMem[base + WW*WL + AW*AL + (i*AL + j)*2]     = rMod[cs][i][j][7:0];
                    romMem[base + WW*WL + AW*AL + (i*AL + j)*2 + 1] = rMod[cs][i][j][15:8];
                end
        end
    endtask

    task automatic checkMatrices(input string tag, input int cs);
        wmat_t ew;
        bmat_t eb;
        rmat_t er;
        for (int i = 0; i < WW; i++) for (int k = 0; k < WL; k++) ew[i][k] = wMod[cs][i][k];
        for (int r = 0; r < AW; r++) for (int c = 0; c < AL; c++) eb[r][c] = bMod[cs][r][c];
        for (int i = 0; i < WW; i++) for (int j = 0; j < AL; j++) er[i][j] = rMod[cs][i][j];
        checkOutput({tag, "_w"}, 128'(data_rom_w), 128'(ew));
        checkOutput({tag, "_b"}, 128'(data_rom_b), 128'(eb));
        checkOutput({tag, "_r"}, 128'(result), 128'(er));
    endtask

    // Issues start at edge 0 and observes cycles 1..CW+6 at the falling edge.
    task automatic applyStimulus(input int sel, input bit pulseBusy,
                                 output int doneCount, output int doneCycle,
                                 output bit seqOk, output int firstAddr, output int lastAddr,
                                 output bit busyOk, output bit validEarly, output bit errSeen);
        int base;
        base = sel * CW;
        doneCount = 0; doneCycle = -1; seqOk = 1'b1; firstAddr = -1; lastAddr = -1;
        busyOk = 1'b1; validEarly = 1'b0; errSeen = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        case_sel = 2'(sel);
        @(posedge clk);
        for (int c = 1; c <= CW + 6; c++) begin
            @(negedge clk);
            if (c <= CW) begin
                if (!(rom_rd_en === 1'b1 && int'(rom_addr) == base + c - 1)) seqOk = 1'b0;
            end else if (rom_rd_en !== 1'b0) seqOk = 1'b0;
            if (c == 1)  firstAddr = int'(rom_addr);
            if (c == CW) lastAddr  = int'(rom_addr);
            if (c <= CW + 1 && busy !== 1'b1) busyOk = 1'b0;
            if (c >= CW + 2 && busy !== 1'b0) busyOk = 1'b0;
            if (c < CW + 2 && data_valid !== 1'b0) validEarly = 1'b1;
            if (done === 1'b1) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = c;
            end
            if (err !== 1'b0) errSeen = 1'b1;
            start    = pulseBusy && (c == 5 || c == 10);
            case_sel = pulseBusy ? 2'(sel + 1) : 2'(sel);
        end
        start = 1'b0;
    endtask

    initial begin
        int  dCount, dCycle, fAddr, lAddr, rndCase;
        bit  sOk, bOk, vEarly, eSeen, rdSeen;

        buildModel();

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",  128'(busy), 128'(0));
        checkOutput("rst_done",  128'(done), 128'(0));
        checkOutput("rst_err",   128'(err), 128'(0));
        checkOutput("rst_valid", 128'(data_valid), 128'(0));
        checkOutput("rst_rden",  128'(rom_rd_en), 128'(0));
        checkOutput("rst_addr",  128'(rom_addr), 128'(0));
        checkOutput("rst_w",     128'(data_rom_w), 128'(0));
        checkOutput("rst_b",     128'(data_rom_b), 128'(0));
        checkOutput("rst_r",     128'(result), 128'(0));
        checkOutput("rst2_busy", 128'(busy2), 128'(0));
        reset_n = 1'b1;

        // Case 0, default image
        applyStimulus(0, 1'b0, dCount, dCycle, sOk, fAddr, lAddr, bOk, vEarly, eSeen);
        checkOutput("c0_addr_seq",   128'(sOk), 128'(1));
        checkOutput("c0_first_addr", 128'(fAddr), 128'(0));
        checkOutput("c0_last_addr",  128'(lAddr), 128'(27));
        checkOutput("c0_done_cycle", 128'(dCycle), 128'(CW + 2));
        checkOutput("c0_done_count", 128'(dCount), 128'(1));
        checkOutput("c0_busy",       128'(bOk), 128'(1));
        checkOutput("c0_valid_early",128'(vEarly), 128'(0));
        checkOutput("c0_err",        128'(eSeen), 128'(0));
        checkOutput("c0_valid",      128'(data_valid), 128'(1));
        checkOutput("c0_w14",        128'(data_rom_w[1][4]), 128'(8'h0e));
        checkOutput("c0_b41",        128'(data_rom_b[4][1]), 128'(8'h09));
        checkOutput("c0_r11",        128'(result[1][1]), 128'(16'h0140));
        checkMatrices("c0", 0);

        // Case 3 with ignored starts while busy
        applyStimulus(3, 1'b1, dCount, dCycle, sOk, fAddr, lAddr, bOk, vEarly, eSeen);
        checkOutput("c3_addr_seq",   128'(sOk), 128'(1));
        checkOutput("c3_first_addr", 128'(fAddr), 128'(84));
        checkOutput("c3_last_addr",  128'(lAddr), 128'(111));
        checkOutput("c3_done_cycle", 128'(dCycle), 128'(CW + 2));
        checkOutput("c3_done_count", 128'(dCount), 128'(1));
        checkOutput("c3_busy",       128'(bOk), 128'(1));
        checkMatrices("c3", 3);
        repeat (5) @(negedge clk);
        checkOutput("c3_hold_valid", 128'(data_valid), 128'(1));
        checkMatrices("c3_hold", 3);

        // Random middle case
        rndCase = int'($urandom_range(1, 2));
        applyStimulus(rndCase, 1'b0, dCount, dCycle, sOk, fAddr, lAddr, bOk, vEarly, eSeen);
        checkOutput("cr_addr_seq",   128'(sOk), 128'(1));
        checkOutput("cr_done_count", 128'(dCount), 128'(1));
        checkOutput("cr_valid_early",128'(vEarly), 128'(0));
        checkMatrices("cr", rndCase);

        // Reset in the middle of a load, then a full reload
        @(negedge clk);
        start    = 1'b1;
        case_sel = 2'd2;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("mid_busy_before", 128'(busy), 128'(1));
        reset_n = 1'b0;
        #1;
        checkOutput("mid_busy",  128'(busy), 128'(0));
        checkOutput("mid_rden",  128'(rom_rd_en), 128'(0));
        checkOutput("mid_valid", 128'(data_valid), 128'(0));
        checkOutput("mid_w",     128'(data_rom_w), 128'(0));
        checkOutput("mid_r",     128'(result), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(2, 1'b0, dCount, dCycle, sOk, fAddr, lAddr, bOk, vEarly, eSeen);
        checkOutput("re_addr_seq",   128'(sOk), 128'(1));
        checkOutput("re_done_cycle", 128'(dCycle), 128'(CW + 2));
        checkMatrices("re", 2);

        // Out-of-range select on the three-case instance
        @(negedge clk);
        start2    = 1'b1;
        case_sel2 = 2'd3;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        rdSeen = rom_rd_en2;
        checkOutput("oor_done",  128'(done2), 128'(1));
        checkOutput("oor_err",   128'(err2), 128'(1));
        checkOutput("oor_busy",  128'(busy2), 128'(0));
        checkOutput("oor_valid", 128'(data_valid2), 128'(0));
        @(negedge clk);
        checkOutput("oor_done_pulse", 128'(done2), 128'(0));
        for (int c = 0; c < 4; c++) begin
            if (rom_rd_en2) rdSeen = 1'b1;
            @(negedge clk);
        end
        checkOutput("oor_no_read",   128'(rdSeen), 128'(0));
        checkOutput("oor_valid_end", 128'(data_valid2), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
